// File: rtl/vga_sync_capture.sv
// Receive-side VGA timing recovery: measures incoming hsync/vsync, locks on stable
// timing, and regenerates screenX/screenY/displayOn aligned to the incoming stream.
module vga_sync_capture #(
    parameter int H_START     = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_START     = 35,
    parameter int V_ACTIVE    = 480,
    parameter int H_MIN       = 700,
    parameter int H_MAX       = 1000,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    output logic        locked,
    output logic        displayOn,
    output logic [9:0]  screenX,
    output logic [8:0]  screenY,
    output logic        frameStart,
    output logic [10:0] lineLength,
    output logic [9:0]  frameLines
);

    localparam int MW = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t          state, state_nxt;
    logic            hs_s1, hs_s2, hs_h, vs_s1, vs_s2, vs_h;
    logic            hs_fall, vs_fall;
    logic [10:0]     h_cnt, period, first_len, first_now, ref_len;
    logic [9:0]      v_cnt, ref_lines;
    logic            have_first, line_bad, line_bad_now, have_now;
    logic            frame_ok, frame_match, in_win, on_nxt;
    logic [MW-1:0]   match_cnt, match_nxt;

    assign hs_fall = hs_h & ~hs_s2;
    assign vs_fall = vs_h & ~vs_s2;
    assign period  = (h_cnt == 11'h7FF) ? h_cnt : h_cnt + 11'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {hs_s1, hs_s2, hs_h} <= 3'b111;
            {vs_s1, vs_s2, vs_h} <= 3'b111;
        end else begin
            hs_s1 <= hsync;
            hs_s2 <= hs_s1;
            hs_h  <= hs_s2;
            vs_s1 <= vsync;
            vs_s2 <= vs_s1;
            vs_h  <= vs_s2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            lineLength <= '0;
            frameLines <= '0;
        end else begin
            if (hs_fall) begin
                h_cnt      <= '0;
                lineLength <= period;
            end else if (h_cnt != 11'h7FF) begin
                h_cnt <= h_cnt + 11'd1;
            end
            if (vs_fall) begin
                v_cnt      <= '0;
                frameLines <= v_cnt;
            end else if (hs_fall && v_cnt != 10'h3FF) begin
                v_cnt <= v_cnt + 10'd1;
            end
        end
    end

    // An hsync fall closes the line that just ended, so one coinciding with vsync
    // still belongs to the frame being closed.
    always_comb begin
        line_bad_now = line_bad;
        if (hs_fall && (period < 11'(H_MIN) || period > 11'(H_MAX) ||
                        (have_first && period != first_len)))
            line_bad_now = 1'b1;
        first_now   = have_first ? first_len : period;
        have_now    = have_first | hs_fall;
        frame_ok    = have_now && !line_bad_now && (v_cnt >= 10'(V_START + V_ACTIVE));
        frame_match = (first_now == ref_len) && (v_cnt == ref_lines);
        match_nxt   = '0;
        if (frame_ok)
            match_nxt = frame_match ? match_cnt + 1'b1 : MW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            have_first <= 1'b0;
            line_bad   <= 1'b0;
            first_len  <= '0;
        end else if (vs_fall) begin
            have_first <= 1'b0;
            line_bad   <= 1'b0;
        end else if (hs_fall) begin
            have_first <= 1'b1;
            first_len  <= first_now;
            line_bad   <= line_bad_now;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SEARCH;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH:  if (vs_fall) state_nxt = MEASURE;
            MEASURE: if (vs_fall && match_nxt == MW'(LOCK_FRAMES)) state_nxt = LOCKED;
            LOCKED:  if ((hs_fall && period != ref_len) ||
                         (!hs_fall && h_cnt == 11'(H_MAX)) ||
                         (vs_fall && v_cnt != ref_lines) ||
                         (v_cnt == 10'h3FF))
                         state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase
    end

    always_comb begin
        locked = (state == LOCKED);
        on_nxt = (state_nxt == LOCKED);
        in_win = (h_cnt >= 11'(H_START)) && (h_cnt < 11'(H_START + H_ACTIVE)) &&
                 (v_cnt >= 10'(V_START)) && (v_cnt < 10'(V_START + V_ACTIVE));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_cnt <= '0;
            ref_len   <= '0;
            ref_lines <= '0;
        end else if (state == SEARCH && vs_fall) begin
            match_cnt <= '0;
        end else if (state == MEASURE && vs_fall) begin
            match_cnt <= match_nxt;
            ref_len   <= first_now;
            ref_lines <= v_cnt;
        end else if (state == LOCKED && state_nxt == SEARCH) begin
            match_cnt <= '0;
        end
    end

    // Gated by the next state so display outputs drop in the same cycle as locked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            displayOn  <= 1'b0;
            screenX    <= '0;
            screenY    <= '0;
            frameStart <= 1'b0;
        end else begin
            displayOn  <= on_nxt && in_win;
            screenX    <= (on_nxt && in_win) ? 10'(h_cnt - 11'(H_START)) : 10'd0;
            screenY    <= (on_nxt && in_win) ? 9'(v_cnt - 10'(V_START)) : 9'd0;
            frameStart <= on_nxt && vs_fall && (state == LOCKED);
        end
    end

endmodule

// File: tb/tb_vga_sync_capture.sv
// Bench for vga_sync_capture on a scaled-down raster: 32 clk/line, hsync low 4,
// 10 lines/frame, vsync low 2 lines falling 2 clocks after the line's hsync fall.
module tb_vga_sync_capture;

    localparam int VLAG = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        locked, displayOn, frameStart;
    logic [9:0]  screenX;
    logic [8:0]  screenY;
    logic [10:0] lineLength;
    logic [9:0]  frameLines;

    int n_cmp  = 0;
    int n_fail = 0;
    int disp_cnt, fs_cnt;
    bit lk_hist [0:15][0:63];
    int ll_hist [0:15];

    vga_sync_capture #(
        .H_START(8), .H_ACTIVE(16), .V_START(3), .V_ACTIVE(4),
        .H_MIN(20), .H_MAX(40), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .locked(locked), .displayOn(displayOn), .screenX(screenX), .screenY(screenY),
        .frameStart(frameStart), .lineLength(lineLength), .frameLines(frameLines)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nl, len, bad_l, bad_len, win_l;
        int lk_l, lk_c, lk_pre, lk_post;
        int ll_l, ll_exp, fl_exp, disp_exp, fs_exp;
    } vec_t;

    vec_t tbl [0:12];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // mode 1: display outputs zero; 2: active-window model; 3: every output zero.
    task automatic do_line(input int l, input int len, input int mode, input int rst_c);
        int hc;
        bit on, in_rst;
        in_rst = 1'b0;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            lk_hist[l][c] = locked;
            if (c == 5) ll_hist[l] = lineLength;
            if (displayOn) disp_cnt++;
            if (frameStart) fs_cnt++;
            hc = c - 4;
            on = (hc >= 8) && (hc < 24) && (l >= 3) && (l < 7);
            if (mode == 3 || in_rst) begin
                chk("all_zero", {locked, displayOn, screenX, screenY, frameStart,
                                 lineLength, frameLines}, 0);
            end else if (mode == 2) begin
                chk("displayOn", displayOn, on);
                chk("screenX", screenX, on ? hc - 8 : 0);
                chk("screenY", screenY, on ? l - 3 : 0);
            end else if (mode == 1) begin
                chk("disp_zero", {displayOn, screenX, screenY}, 0);
            end
            if (c == rst_c) begin
                chk("rst_pre_disp", displayOn, 1);
                rst = 1'b0;
                #1;
                chk("rst_async", {locked, displayOn, screenX, screenY, frameStart,
                                  lineLength, frameLines}, 0);
                in_rst = 1'b1;
            end
            hsync = (c < 4) ? 1'b0 : 1'b1;
            vsync = ((l == 0 && c >= VLAG) || l == 1) ? 1'b0 : 1'b1;
        end
        if (in_rst) rst = 1'b1;
    endtask

    task automatic do_frame(input int nl, input int len, input int bad_l, input int bad_len,
                            input int win_l, input int rst_l, input int rst_c);
        disp_cnt = 0;
        fs_cnt   = 0;
        for (int l = 0; l < nl; l++)
            do_line(l, (l == bad_l) ? bad_len : len, (l < win_l) ? 2 : 1,
                    (l == rst_l) ? rst_c : -1);
    endtask

    initial begin
        //            nl len bad blen win lk_l lk_c pre post ll_l ll  fl disp fs
        tbl[0]  = '{10, 32, -1,  0,  0,  0,   5,   0,  0,   9,  32,  1,  0, 0};
        tbl[1]  = '{10, 32, -1,  0,  0,  0,   5,   0,  0,   9,  32, 10,  0, 0};
        tbl[2]  = '{10, 32, -1,  0, 10,  0,   5,   0,  1,   9,  32, 10, 64, 0};
        tbl[3]  = '{10, 32, -1,  0, 10,  0,   5,   1,  1,   9,  32, 10, 64, 1};
        tbl[4]  = '{10, 32,  4, 33,  5,  5,   3,   1,  0,   5,  33, 10, 32, 1};
        tbl[5]  = '{10, 32, -1,  0,  0,  0,   5,   0,  0,   9,  32, 10,  0, 0};
        tbl[6]  = '{10, 32, -1,  0,  0,  0,   5,   0,  0,   9,  32, 10,  0, 0};
        tbl[7]  = '{10, 32, -1,  0, 10,  0,   5,   0,  1,   9,  32, 10, 64, 0};
        tbl[8]  = '{ 9, 32, -1,  0,  9,  0,   5,   1,  1,   8,  32, 10, 64, 1};
        tbl[9]  = '{10, 32, -1,  0,  0,  0,   5,   1,  0,   9,  32,  9,  0, 0};
        tbl[10] = '{10, 32, -1,  0,  0,  0,   5,   0,  0,   9,  32, 10,  0, 0};
        tbl[11] = '{10, 32, -1,  0,  0,  0,   5,   0,  0,   9,  32, 10,  0, 0};
        tbl[12] = '{10, 32, -1,  0, 10,  0,   5,   0,  1,   9,  32, 10, 64, 0};

        // Reset held while the syncs toggle.
        do_line(0, 32, 3, -1);
        do_line(1, 32, 3, -1);
        @(negedge clk);
        hsync = 1'b1;
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_locked", locked, 0);
        chk("idle_lineLength", lineLength, 0);
        chk("idle_frameLines", frameLines, 0);

        for (int i = 0; i < 13; i++) begin
            do_frame(tbl[i].nl, tbl[i].len, tbl[i].bad_l, tbl[i].bad_len, tbl[i].win_l, -1, -1);
            chk($sformatf("f%0d_lock_pre", i), lk_hist[tbl[i].lk_l][tbl[i].lk_c - 1], tbl[i].lk_pre);
            chk($sformatf("f%0d_lock_post", i), lk_hist[tbl[i].lk_l][tbl[i].lk_c], tbl[i].lk_post);
            chk($sformatf("f%0d_lineLength", i), ll_hist[tbl[i].ll_l], tbl[i].ll_exp);
            chk($sformatf("f%0d_frameLines", i), frameLines, tbl[i].fl_exp);
            chk($sformatf("f%0d_disp_cycles", i), disp_cnt, tbl[i].disp_exp);
            chk($sformatf("f%0d_frameStart", i), fs_cnt, tbl[i].fs_exp);
        end

        // hsync loss while locked: timeout once h_cnt reaches H_MAX.
        do_line(5, 60, 1, -1);
        chk("loss_lock_pre", lk_hist[5][43], 1);
        chk("loss_lock_post", lk_hist[5][44], 0);

        // Relock, then reset during active video.
        do_frame(10, 32, -1, 0, 0, -1, -1);
        chk("relA_lock", lk_hist[0][5], 0);
        do_frame(10, 32, -1, 0, 0, -1, -1);
        chk("relB_lock", lk_hist[0][5], 0);
        do_frame(10, 32, -1, 0, 10, -1, -1);
        chk("relC_lock_pre", lk_hist[0][4], 0);
        chk("relC_lock_post", lk_hist[0][5], 1);
        do_frame(10, 32, -1, 0, 4, 3, 16);
        chk("rstD_locked_end", locked, 0);
        do_frame(10, 32, -1, 0, 0, -1, -1);
        chk("rstE_lock", lk_hist[0][5], 0);
        do_frame(10, 32, -1, 0, 0, -1, -1);
        chk("rstF_lock", lk_hist[0][5], 0);
        do_frame(10, 32, -1, 0, 10, -1, -1);
        chk("rstG_lock_pre", lk_hist[0][4], 0);
        chk("rstG_lock_post", lk_hist[0][5], 1);
        chk("rstG_disp_cycles", disp_cnt, 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
